// File: rtl/m65_keyscan_serializer.sv
// MEGA65 keyboard scanner: synchronises the parallel active-low key vector, debounces each key
// on its scan visit, and presents a rotating key_num / key_status_n stream to the ZX-Uno core.
module m65_keyscan_serializer #(
  parameter int unsigned NUM_KEYS = 80,
  parameter int unsigned DWELL    = 4,
  parameter int unsigned DEBOUNCE = 3
) (
  input  logic                clk28mhz,
  input  logic                reset,
  input  logic [NUM_KEYS-1:0] key_raw_n,
  output logic [6:0]          key_num,
  output logic                key_status_n,
  output logic                key_strobe,
  output logic                scan_wrap,
  output logic                any_pressed
);

  localparam int unsigned IdxW = (NUM_KEYS > 1) ? $clog2(NUM_KEYS) : 1;
  localparam int unsigned DwW  = $clog2(DWELL);

  localparam logic [IdxW-1:0] LastIdx   = IdxW'(NUM_KEYS - 1);
  localparam logic [DwW-1:0]  DwellLast = DwW'(DWELL - 1);
  localparam logic [1:0]      DebLast   = 2'(DEBOUNCE - 1);

  logic [NUM_KEYS-1:0] sync1_q;
  logic [NUM_KEYS-1:0] raw_s_q;
  logic [NUM_KEYS-1:0] stable_q, stable_d;
  logic [1:0]          cnt_q [NUM_KEYS];
  logic [DwW-1:0]      dwell_q, dwell_d;
  logic [IdxW-1:0]     idx_q, idx_d;
  logic                status_q, status_d;
  logic                strobe_q, wrap_q, any_q;

  logic       eval;
  logic       cur_raw, cur_stable, stable_new;
  logic [1:0] cur_cnt, cnt_new;

  assign eval       = (dwell_q == DwellLast);
  assign cur_raw    = raw_s_q[idx_q];
  assign cur_stable = stable_q[idx_q];
  assign cur_cnt    = cnt_q[idx_q];

  // Visit-based debounce: any visit agreeing with the committed state clears the count.
  always_comb begin
    cnt_new    = cur_cnt;
    stable_new = cur_stable;
    if (cur_raw == cur_stable) begin
      cnt_new = 2'd0;
    end else if (cur_cnt == DebLast) begin
      stable_new = cur_raw;
      cnt_new    = 2'd0;
    end else begin
      cnt_new = cur_cnt + 2'd1;
    end
  end

  always_comb begin
    stable_d = stable_q;
    idx_d    = idx_q;
    dwell_d  = dwell_q + DwW'(1);
    status_d = status_q;
    if (eval) begin
      stable_d[idx_q] = stable_new;
      idx_d           = (idx_q == LastIdx) ? '0 : idx_q + IdxW'(1);
      dwell_d         = '0;
      // idx_d never equals idx_q, so this reads the already-committed state of the next key.
      status_d        = stable_d[idx_d];
    end
  end

  always_ff @(posedge clk28mhz) begin
    if (reset) begin
      sync1_q  <= '1;
      raw_s_q  <= '1;
      stable_q <= '1;
      for (int k = 0; k < NUM_KEYS; k++) begin
        cnt_q[k] <= 2'd0;
      end
      dwell_q  <= '0;
      idx_q    <= '0;
      status_q <= 1'b1;
      strobe_q <= 1'b0;
      wrap_q   <= 1'b0;
      any_q    <= 1'b0;
    end else begin
      sync1_q  <= key_raw_n;
      raw_s_q  <= sync1_q;
      stable_q <= stable_d;
      if (eval) begin
        cnt_q[idx_q] <= cnt_new;
      end
      dwell_q  <= dwell_d;
      idx_q    <= idx_d;
      status_q <= status_d;
      strobe_q <= (dwell_d == '0);
      wrap_q   <= (dwell_d == '0) && (idx_d == '0);
      any_q    <= ~&stable_q;
    end
  end

  assign key_num      = 7'(idx_q);
  assign key_status_n = status_q;
  assign key_strobe   = strobe_q;
  assign scan_wrap    = wrap_q;
  assign any_pressed  = any_q;

endmodule
